// File: rtl/vga_timing_if.sv
// VGA raster timing bundle: pixel enable in, coordinates/sync/strobes out.
// The generator uses the master modport; pixel stages use the slave modport.
interface vga_timing_if;
    logic       pix_en;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       hs;
    logic       vs;
    logic       blank;
    logic       frame_start;
    logic       vblank_start;
    logic [7:0] frame_count;

    modport master (
        input  pix_en,
        output DrawX, DrawY, hs, vs, blank,
        output frame_start, vblank_start, frame_count
    );

    modport slave (
        output pix_en,
        input  DrawX, DrawY, hs, vs, blank,
        input  frame_start, vblank_start, frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster generator: counters, sync/blank decode with a
// pixel-enable delay line, frame/vblank strobes and a frame counter.
module vga_timing_gen #(
    parameter int H_VIS      = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VIS      = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit SYNC_POL   = 1'b0,
    parameter int PIPE_DELAY = 1
) (
    input  logic         vga_clk,
    input  logic         reset_n,
    vga_timing_if.master vif
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOT > 1024 || V_TOT > 1024) begin : g_bad_tot
            $error("vga_timing_gen: H_TOT/V_TOT exceed 10-bit counters");
        end
        if (PIPE_DELAY < 0 || PIPE_DELAY > 4) begin : g_bad_delay
            $error("vga_timing_gen: PIPE_DELAY must be 0..4");
        end
    endgenerate

    localparam logic [9:0]  X_LAST = 10'(H_TOT - 1);
    localparam logic [9:0]  Y_LAST = 10'(V_TOT - 1);
    localparam logic [9:0]  Y_VBL  = 10'(V_VIS);
    localparam logic [10:0] X_VIS  = 11'(H_VIS);
    localparam logic [10:0] Y_VIS  = 11'(V_VIS);
    localparam logic [10:0] HS_BEG = 11'(H_VIS + H_FP);
    localparam logic [10:0] HS_END = 11'(H_VIS + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG = 11'(V_VIS + V_FP);
    localparam logic [10:0] VS_END = 11'(V_VIS + V_FP + V_SYNC);

    // {hs, vs, blank} with sync deasserted and nothing visible
    localparam logic [2:0] INACT = {~SYNC_POL, ~SYNC_POL, 1'b0};

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic [7:0]  fc_q, fc_d;
    logic        fs_q, fs_d;
    logic        vbs_q, vbs_d;
    logic [2:0]  pipe_q [0:PIPE_DELAY];
    logic [2:0]  pipe_d [0:PIPE_DELAY];
    logic        adv;
    logic        hs_n, vs_n, bl_n;

    // Next raster position, strobes and sync/blank delay line
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        fc_d    = fc_q;
        fs_d    = 1'b0;
        vbs_d   = 1'b0;
        adv     = 1'b0;
        pipe_d  = pipe_q;

        unique case (state_q)
            IDLE: begin
                if (vif.pix_en) begin
                    state_d = RUN;
                    x_d     = '0;
                    y_d     = '0;
                    adv     = 1'b1;
                end
            end
            RUN: begin
                if (vif.pix_en) begin
                    adv = 1'b1;
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        if (y_q == Y_LAST) begin
                            y_d  = '0;
                            fc_d = fc_q + 8'd1;
                        end else begin
                            y_d = y_q + 10'd1;
                        end
                    end else begin
                        x_d = x_q + 10'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        hs_n = ({1'b0, x_d} >= HS_BEG && {1'b0, x_d} < HS_END)
               ? SYNC_POL : ~SYNC_POL;
        vs_n = ({1'b0, y_d} >= VS_BEG && {1'b0, y_d} < VS_END)
               ? SYNC_POL : ~SYNC_POL;
        bl_n = ({1'b0, x_d} < X_VIS) && ({1'b0, y_d} < Y_VIS);

        if (adv) begin
            fs_d      = (x_d == 10'd0) && (y_d == 10'd0);
            vbs_d     = (x_d == 10'd0) && (y_d == Y_VBL);
            pipe_d[0] = {hs_n, vs_n, bl_n};
            for (int i = 1; i <= PIPE_DELAY; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
        end
    end

    // State register with asynchronous clear to idle/inactive
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            fc_q    <= '0;
            fs_q    <= 1'b0;
            vbs_q   <= 1'b0;
            for (int i = 0; i <= PIPE_DELAY; i++) begin
                pipe_q[i] <= INACT;
            end
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            fc_q    <= fc_d;
            fs_q    <= fs_d;
            vbs_q   <= vbs_d;
            pipe_q  <= pipe_d;
        end
    end

    assign vif.DrawX        = x_q;
    assign vif.DrawY        = y_q;
    assign vif.hs           = pipe_q[PIPE_DELAY][2];
    assign vif.vs           = pipe_q[PIPE_DELAY][1];
    assign vif.blank        = pipe_q[PIPE_DELAY][0];
    assign vif.frame_start  = fs_q;
    assign vif.vblank_start = vbs_q;
    assign vif.frame_count  = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (full timing with delay 0 and 2,
// and a tiny active-high raster with delay 3) against an arithmetic model.
module tb_vga_timing_gen;

    typedef struct {
        int x;
        int y;
        int hs;
        int vs;
        int bl;
        int fs;
        int vb;
        int fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic pix_en;

    int ncmp = 0;
    int nerr = 0;
    int n    = -1;
    bit strb = 1'b0;
    int cyc  = 0;
    int phase = 0;
    int last_fs = -1;
    int hs_cnt = 0;

    always #5 clk = ~clk;

    vga_timing_if ia ();
    vga_timing_if ib ();
    vga_timing_if ic ();

    assign ia.pix_en = pix_en;
    assign ib.pix_en = pix_en;
    assign ic.pix_en = pix_en;

    vga_timing_gen #(.PIPE_DELAY(0)) ua (
        .vga_clk(clk), .reset_n(rst_n), .vif(ia)
    );

    vga_timing_gen #(.PIPE_DELAY(2)) ub (
        .vga_clk(clk), .reset_n(rst_n), .vif(ib)
    );

    vga_timing_gen #(
        .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b1), .PIPE_DELAY(3)
    ) uc (
        .vga_clk(clk), .reset_n(rst_n), .vif(ic)
    );

    // n = index of the presented pixel since start (-1 before start)
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n    <= -1;
            strb <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            if (pix_en) begin
                n    <= n + 1;
                strb <= 1'b1;
            end else begin
                strb <= 1'b0;
            end
        end
    end

    function automatic exp_t model(
        int k, bit s,
        int hv, int hf, int hsy, int hb,
        int vv, int vf, int vsy, int vbp,
        int d, bit pol
    );
        exp_t e;
        int ht, vt, m, mx, my;
        ht = hv + hf + hsy + hb;
        vt = vv + vf + vsy + vbp;
        e.x = 0; e.y = 0; e.fs = 0; e.vb = 0; e.fc = 0;
        e.hs = pol ? 0 : 1;
        e.vs = pol ? 0 : 1;
        e.bl = 0;
        if (k >= 0) begin
            e.x  = k % ht;
            e.y  = (k / ht) % vt;
            e.fc = (k / (ht * vt)) % 256;
            e.fs = (s && e.x == 0 && e.y == 0) ? 1 : 0;
            e.vb = (s && e.x == 0 && e.y == vv) ? 1 : 0;
            m = k - d;
            if (m >= 0) begin
                mx = m % ht;
                my = (m / ht) % vt;
                if (mx >= hv + hf && mx < hv + hf + hsy) e.hs = pol ? 1 : 0;
                if (my >= vv + vf && my < vv + vf + vsy) e.vs = pol ? 1 : 0;
                e.bl = (mx < hv && my < vv) ? 1 : 0;
            end
        end
        return e;
    endfunction

    task automatic chk(string name, int act, int exp);
        ncmp++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, want %0d (n=%0d t=%0t)",
                     name, act, exp, n, $time);
        end
    endtask

    task automatic cmp(string t, exp_t e,
                       int x, int y, int hs, int vs, int bl,
                       int fs, int vb, int fc);
        chk({t, ".DrawX"}, x, e.x);
        chk({t, ".DrawY"}, y, e.y);
        chk({t, ".hs"}, hs, e.hs);
        chk({t, ".vs"}, vs, e.vs);
        chk({t, ".blank"}, bl, e.bl);
        chk({t, ".frame_start"}, fs, e.fs);
        chk({t, ".vblank_start"}, vb, e.vb);
        chk({t, ".frame_count"}, fc, e.fc);
    endtask

    // Per-cycle comparison of all instances, plus hand-computed pins
    always @(negedge clk) begin
        exp_t ea, eb, ec;
        ea = model(n, strb, 640, 16, 96, 48, 480, 10, 2, 33, 0, 1'b0);
        eb = model(n, strb, 640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0);
        ec = model(n, strb, 8, 2, 3, 2, 4, 1, 2, 1, 3, 1'b1);
        cmp("A", ea, int'(ia.DrawX), int'(ia.DrawY), int'(ia.hs),
            int'(ia.vs), int'(ia.blank), int'(ia.frame_start),
            int'(ia.vblank_start), int'(ia.frame_count));
        cmp("B", eb, int'(ib.DrawX), int'(ib.DrawY), int'(ib.hs),
            int'(ib.vs), int'(ib.blank), int'(ib.frame_start),
            int'(ib.vblank_start), int'(ib.frame_count));
        cmp("C", ec, int'(ic.DrawX), int'(ic.DrawY), int'(ic.hs),
            int'(ic.vs), int'(ic.blank), int'(ic.frame_start),
            int'(ic.vblank_start), int'(ic.frame_count));

        if (n < 0) hs_cnt = 0;
        else if (strb && n < 800 && ia.hs == 1'b0) hs_cnt++;

        if (strb) begin
            if (n == 0) begin
                chk("pin.A.first.DrawX", int'(ia.DrawX), 0);
                chk("pin.A.first.blank", int'(ia.blank), 1);
                chk("pin.A.first.fs", int'(ia.frame_start), 1);
                chk("pin.A.first.fc", int'(ia.frame_count), 0);
                chk("pin.B.first.blank", int'(ib.blank), 0);
            end
            if (n == 1) chk("pin.B.second.blank", int'(ib.blank), 0);
            if (n == 2) chk("pin.B.third.blank", int'(ib.blank), 1);
            if (n == 639) begin
                chk("pin.A.639.DrawX", int'(ia.DrawX), 639);
                chk("pin.A.639.blank", int'(ia.blank), 1);
            end
            if (n == 640) begin
                chk("pin.A.640.DrawX", int'(ia.DrawX), 640);
                chk("pin.A.640.blank", int'(ia.blank), 0);
            end
            if (n == 641) chk("pin.B.641.blank", int'(ib.blank), 1);
            if (n == 642) chk("pin.B.642.blank", int'(ib.blank), 0);
            if (n == 655) chk("pin.A.655.hs", int'(ia.hs), 1);
            if (n == 656) chk("pin.A.656.hs", int'(ia.hs), 0);
            if (n == 657) chk("pin.B.657.hs", int'(ib.hs), 1);
            if (n == 658) chk("pin.B.658.hs", int'(ib.hs), 0);
            if (n == 60) chk("pin.C.vblank", int'(ic.vblank_start), 1);
            if (n == 120) chk("pin.C.120.fc", int'(ic.frame_count), 1);
            if (n == 799) chk("pin.A.799.DrawX", int'(ia.DrawX), 799);
            if (n == 800) begin
                chk("pin.A.800.DrawX", int'(ia.DrawX), 0);
                chk("pin.A.800.DrawY", int'(ia.DrawY), 1);
                chk("pin.A.hs_width", hs_cnt, 96);
            end
            if (n == 30719) chk("pin.C.fc255", int'(ic.frame_count), 255);
            if (n == 30720) begin
                chk("pin.C.wrap.fc", int'(ic.frame_count), 0);
                chk("pin.C.wrap.fs", int'(ic.frame_start), 1);
                chk("pin.A.30720.DrawX", int'(ia.DrawX), 320);
                chk("pin.A.30720.DrawY", int'(ia.DrawY), 38);
            end
        end

        if (phase == 2 && ic.frame_start) begin
            if (last_fs >= 0) chk("pin.C.fs_period", cyc - last_fs, 240);
            last_fs = cyc;
        end
    end

    // Stimulus: idle, constant enable, /2 enable, random, async reset, long run
    initial begin
        int waited;
        rst_n  = 1'b0;
        pix_en = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        phase  = 1;
        pix_en = 1'b1;
        repeat (1000) @(negedge clk);

        phase = 2;
        repeat (1000) begin
            pix_en = ~pix_en;
            @(negedge clk);
        end

        phase  = 3;
        waited = 0;
        while (!(n >= 800 && n % 800 == 300) && waited < 5000) begin
            pix_en = ($urandom % 10) < 7;
            @(negedge clk);
            waited++;
        end
        if (waited >= 5000) chk("reset_point_timeout", 0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async.A.DrawX", int'(ia.DrawX), 0);
        chk("async.A.DrawY", int'(ia.DrawY), 0);
        chk("async.A.hs", int'(ia.hs), 1);
        chk("async.A.blank", int'(ia.blank), 0);
        chk("async.B.vs", int'(ib.vs), 1);
        chk("async.C.hs", int'(ic.hs), 0);
        chk("async.C.fc", int'(ic.frame_count), 0);
        chk("async.C.fs", int'(ic.frame_start), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        phase  = 4;
        waited = 0;
        while (n <= 30722 && waited < 40000) begin
            pix_en = ($urandom % 10) < 9;
            @(negedge clk);
            waited++;
        end
        if (waited >= 40000) chk("frame_wrap_timeout", 0, 1);
        pix_en = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
